terrain_column_renderer: RTL and testbench
==========================================

Name: terrain_column_renderer

Overview:
- Downstream consumer of the double-buffered terrain height stream (8-bit `oy`) in the Melody Odyssey game.
- For each frame, sweeps every screen column, fetches that column's ground height, and paints the column top-to-bottom.
- Rows above the height are sky; rows at and below it are ground.
- Drives the VGA adapter's plot interface (x, y, colour, plot) at one pixel per clock.

Parameters:
- H_RES, 160, number of columns swept (x = 0..H_RES-1).
- V_RES, 120, number of rows per column (y = 0..V_RES-1).
- READ_LATENCY, 2, cycles from height_req to valid height_in (minimum 1).
- SKY_COLOUR, 3'b000, colour for rows y < height.
- GROUND_COLOUR, 3'b010, colour for rows y >= height.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a frame render; ignored unless the FSM is in IDLE.
- height_in  in  8  column height from the double-buffer output; sampled READ_LATENCY cycles after height_req.
- height_req  out  1  one-cycle pulse requesting the height of column req_col.
- req_col  out  8  column index being requested or drawn.
- x  out  8  plot column.
- y  out  7  plot row.
- colour  out  3  plot colour.
- plot  out  1  pixel write strobe; x, y and colour are valid when this is high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last pixel of the frame has been plotted.

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE.
  - height_req, req_col, x, y, colour, plot, busy and done are all 0.
  - Internal column/row counters and the height register clear.
  - Reset mid-frame aborts the frame immediately; no done pulse is produced.
- States: IDLE, REQ, WAIT, DRAW, NEXT, FIN.
- IDLE:
  - start=1 moves to REQ with col=0; busy rises next cycle.
  - start outside IDLE is ignored and does not queue.
- REQ (1 cycle):
  - height_req=1, req_col=col.
  - Goes to WAIT with wait counter = READ_LATENCY-1.
- WAIT:
  - Counts down to 0.
  - On the cycle the counter is 0, height_in is registered into hgt, row is set to 0, and the FSM goes to DRAW.
- DRAW (V_RES cycles):
  - plot=1, x=col, y=row.
  - colour = GROUND_COLOUR if row >= hgt (8-bit unsigned compare), else SKY_COLOUR.
  - row increments each cycle; after row V_RES-1 goes to NEXT.
- NEXT (1 cycle):
  - plot=0.
  - If col == H_RES-1, go to FIN; else col+1 and go to REQ.
- FIN (1 cycle): done=1, busy=0, go to IDLE.
- Boundary cases:
  - hgt >= V_RES (up to 255): whole column is sky.
  - hgt = 0: whole column is ground.
- Timing:
  - Per-column cost is 1 + READ_LATENCY + V_RES + 1 cycles (124 at defaults).
  - Frame length at defaults is 160*124 = 19840 cycles from REQ of column 0 to the end of NEXT of column 159, then done.
- Outputs:
  - All outputs are registered.
  - plot is never high outside DRAW.
  - height_req is never high outside REQ.

Optional Feature:
- Macro: TERRAIN_OUTLINE_EN.
- Defined: the row where row == hgt (only when hgt < V_RES) is drawn in colour 3'b111 (outline). Rows above it are sky; rows below it are ground.
- Undefined: plain two-colour fill as described in Behaviour; no outline logic is synthesised.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> all outputs 0, FSM in IDLE. Deassert with no start -> outputs stay 0 for 100 cycles.
- Constant height 100 for every column, pulse start -> exactly 19200 plot strobes. Column 0 rows 0..99 are colour 000 and rows 100..119 are colour 010. done pulses once, exactly 19841 cycles after start was sampled.
- Per-column heights col 0 = 0, col 1 = 119, col 2 = 200 -> col 0 is all ground, col 1 has only row 119 as ground, col 2 is all sky. height_req fires exactly 160 times with req_col 0..159 in order.
- Start re-pulsed at cycle 500 while busy -> ignored; the frame still completes with a single done and exactly 19200 plots.
- resetn asserted during DRAW of column 37 -> plot and busy drop to 0 asynchronously; no done. A new start then renders a full frame from column 0.
- With TERRAIN_OUTLINE_EN, height 60 -> rows 0..59 colour 000, row 60 colour 111, rows 61..119 colour 010. Height 130 -> no 111 pixel in that column.

Source files
------------

// File: rtl/terrain_column_renderer.sv
// terrain_column_renderer: paints each screen column as sky above its terrain height and ground at/below it.
// Define TERRAIN_OUTLINE_EN to draw the row at the terrain height in white as an outline.
module terrain_column_renderer #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int READ_LATENCY = 2,
  parameter logic [2:0] SKY_COLOUR = 3'b000,
  parameter logic [2:0] GROUND_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] height_in,
  output logic       height_req,
  output logic [7:0] req_col,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAW, NEXT, FIN} state_t;
  state_t state;
  logic [7:0] col, hgt, wcnt;
  logic [6:0] row;
  function automatic logic [2:0] shade(input logic [6:0] r, input logic [7:0] h);
`ifdef TERRAIN_OUTLINE_EN
    // row < V_RES always, so row == h already implies h < V_RES
    return ({1'b0, r} == h) ? 3'b111 : ({1'b0, r} > h) ? GROUND_COLOUR : SKY_COLOUR;
`else
    return ({1'b0, r} >= h) ? GROUND_COLOUR : SKY_COLOUR;
`endif
  endfunction
  // Outputs are assigned alongside the state transition so they line up with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      col <= '0;
      hgt <= '0;
      wcnt <= '0;
      row <= '0;
      height_req <= 1'b0;
      req_col <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          col <= '0;
          req_col <= '0;
          height_req <= 1'b1;
          busy <= 1'b1;
        end
        REQ: begin
          state <= WAIT;
          height_req <= 1'b0;
          wcnt <= 8'(READ_LATENCY - 1);
        end
        WAIT: if (wcnt == 8'd0) begin
          state <= DRAW;
          hgt <= height_in;
          row <= '0;
          plot <= 1'b1;
          x <= col;
          y <= '0;
          colour <= shade(7'd0, height_in);
        end else
          wcnt <= wcnt - 8'd1;
        DRAW: if (row == 7'(V_RES - 1)) begin
          state <= NEXT;
          plot <= 1'b0;
        end else begin
          row <= row + 7'd1;
          y <= row + 7'd1;
          colour <= shade(row + 7'd1, hgt);
        end
        NEXT: if (col == 8'(H_RES - 1)) begin
          state <= FIN;
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          state <= REQ;
          col <= col + 8'd1;
          req_col <= col + 8'd1;
          height_req <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_terrain_column_renderer.sv
// tb_terrain_column_renderer: randomized frames checked against a per-pixel sky/ground model.
module tb_terrain_column_renderer;
  localparam int H = 160;
  localparam int V = 120;
  localparam int FRAME = 19841;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [7:0] height_in, p1;
  logic height_req, plot, busy, done;
  logic [7:0] req_col, x;
  logic [6:0] y;
  logic [2:0] colour;
  int checks = 0, errors = 0;
  int plots, dones, done_n, oob;
  int reqs[$];
  logic [7:0] heights[H];
  logic [2:0] fb[H][V];

  terrain_column_renderer dut (
    .clk(clk), .resetn(resetn), .start(start), .height_in(height_in),
    .height_req(height_req), .req_col(req_col), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Height memory with a two-cycle read; junk between reads exposes early sampling.
  always @(posedge clk) begin
    p1 <= (height_req && req_col < H) ? heights[req_col] : 8'hee;
    height_in <= p1;
  end

  function automatic logic [2:0] expect_colour(int c, int r);
`ifdef TERRAIN_OUTLINE_EN
    if (r == int'(heights[c])) return 3'b111;
`endif
    return (r >= int'(heights[c])) ? 3'b010 : 3'b000;
  endfunction

  function automatic int bad_pixels();
    int b = 0;
    for (int c = 0; c < H; c++)
      for (int r = 0; r < V; r++)
        if (fb[c][r] !== expect_colour(c, r)) b++;
    return b;
  endfunction

  task automatic randomize_heights();
    for (int c = 0; c < H; c++) heights[c] = 8'($urandom_range(0, 255));
  endtask

  // Runs one frame from a start pulse, capturing plotted pixels, requests and done timing.
  task automatic run_frame(input int repulse);
    plots = 0; dones = 0; done_n = 0; oob = 0;
    reqs.delete();
    for (int c = 0; c < H; c++)
      for (int r = 0; r < V; r++) fb[c][r] = 3'bxxx;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 25000; n++) begin
      start = (n == repulse);
      if (plot) begin
        plots++;
        if (x < H && y < V) fb[x][y] = colour; else oob++;
      end
      if (height_req) reqs.push_back(int'(req_col));
      if (done) begin
        dones++;
        if (done_n == 0) done_n = n;
      end
      if (done_n != 0 && n >= done_n + 5) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int nz = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({height_req, req_col, x, y, colour, plot, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b col=%0d x=%0d y=%0d c=%b plot=%b busy=%b done=%b want all 0",
               height_req, req_col, x, y, colour, plot, busy, done);
    end
    resetn = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if ({height_req, req_col, x, y, colour, plot, busy, done} !== '0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL idle_quiet got %0d nonzero cycles want 0", nz);
    end
  endtask

  task automatic test_constant_height();
    int b;
    for (int c = 0; c < H; c++) heights[c] = 8'd100;
    run_frame(0);
    b = bad_pixels();
    checks++; if (plots != H * V) begin errors++; $display("FAIL const_plots got %0d want %0d", plots, H * V); end
    checks++; if (dones != 1) begin errors++; $display("FAIL const_dones got %0d want 1", dones); end
    checks++; if (done_n != FRAME) begin errors++; $display("FAIL const_done_time got %0d want %0d", done_n, FRAME); end
    checks++; if (b != 0) begin errors++; $display("FAIL const_pixels got %0d bad want 0", b); end
    checks++; if (fb[0][99] !== 3'b000) begin errors++; $display("FAIL const_row99 got %b want 000", fb[0][99]); end
    checks++; if (fb[0][100] !== 3'b010) begin errors++; $display("FAIL const_row100 got %b want 010", fb[0][100]); end
    checks++; if (oob != 0) begin errors++; $display("FAIL const_oob got %0d want 0", oob); end
  endtask

  task automatic test_boundaries();
    int g0 = 0, g1 = 0, s2 = 0, order = 0, b;
    randomize_heights();
    heights[0] = 8'd0; heights[1] = 8'd119; heights[2] = 8'd200;
    run_frame(0);
    for (int r = 0; r < V; r++) begin
`ifndef TERRAIN_OUTLINE_EN
      if (fb[0][r] === 3'b010) g0++;
      if (fb[1][r] === 3'b010) g1++;
`endif
      if (fb[2][r] === 3'b000) s2++;
    end
    for (int i = 0; i < reqs.size(); i++) if (reqs[i] != i) order++;
    b = bad_pixels();
`ifndef TERRAIN_OUTLINE_EN
    checks++; if (g0 != V) begin errors++; $display("FAIL h0_ground got %0d rows want %0d", g0, V); end
    checks++; if (g1 != 1 || fb[1][119] !== 3'b010) begin errors++; $display("FAIL h119_ground got %0d rows row119=%b want 1 row 010", g1, fb[1][119]); end
`endif
    checks++; if (s2 != V) begin errors++; $display("FAIL h200_sky got %0d rows want %0d", s2, V); end
    checks++; if (reqs.size() != H) begin errors++; $display("FAIL req_count got %0d want %0d", reqs.size(), H); end
    checks++; if (order != 0) begin errors++; $display("FAIL req_order got %0d out of order want 0", order); end
    checks++; if (b != 0) begin errors++; $display("FAIL bound_pixels got %0d bad want 0", b); end
  endtask

  task automatic test_start_ignored();
    int b;
    randomize_heights();
    run_frame(500);
    b = bad_pixels();
    checks++; if (dones != 1) begin errors++; $display("FAIL restart_dones got %0d want 1", dones); end
    checks++; if (plots != H * V) begin errors++; $display("FAIL restart_plots got %0d want %0d", plots, H * V); end
    checks++; if (done_n != FRAME) begin errors++; $display("FAIL restart_done_time got %0d want %0d", done_n, FRAME); end
    checks++; if (b != 0) begin errors++; $display("FAIL restart_pixels got %0d bad want 0", b); end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0, stray = 0, b;
    randomize_heights();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 6000 && !seen; n++) begin
      if (plot && x == 8'd37) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reach_col37 got timeout want plot on col 37"); end
    resetn = 1'b0;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async got plot=%b busy=%b want 0 0", plot, busy); end
    repeat (3) begin @(negedge clk); if (done) stray++; end
    resetn = 1'b1;
    repeat (20) begin @(negedge clk); if (done || busy) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_done got %0d done/busy cycles want 0", stray); end
    run_frame(0);
    b = bad_pixels();
    checks++; if (plots != H * V || dones != 1) begin errors++; $display("FAIL mid_rerun got plots=%0d dones=%0d want %0d 1", plots, dones, H * V); end
    checks++; if (reqs.size() == 0 || reqs[0] != 0) begin errors++; $display("FAIL mid_first_col got %0d reqs first=%0d want col 0", reqs.size(), reqs.size() ? reqs[0] : -1); end
    checks++; if (b != 0) begin errors++; $display("FAIL mid_pixels got %0d bad want 0", b); end
  endtask

`ifdef TERRAIN_OUTLINE_EN
  task automatic test_outline();
    int w0 = 0, w1 = 0, b;
    randomize_heights();
    heights[0] = 8'd60; heights[1] = 8'd130;
    run_frame(0);
    for (int r = 0; r < V; r++) begin
      if (fb[0][r] === 3'b111) w0++;
      if (fb[1][r] === 3'b111) w1++;
    end
    b = bad_pixels();
    checks++; if (fb[0][60] !== 3'b111 || w0 != 1) begin errors++; $display("FAIL outline_60 got row60=%b white=%0d want 111 1", fb[0][60], w0); end
    checks++; if (fb[0][59] !== 3'b000 || fb[0][61] !== 3'b010) begin errors++; $display("FAIL outline_neighbours got %b %b want 000 010", fb[0][59], fb[0][61]); end
    checks++; if (w1 != 0) begin errors++; $display("FAIL outline_130 got %0d white want 0", w1); end
    checks++; if (b != 0) begin errors++; $display("FAIL outline_pixels got %0d bad want 0", b); end
  endtask
`endif

  initial begin
    test_reset();
    test_constant_height();
    test_boundaries();
    test_start_ignored();
    test_reset_mid_frame();
`ifdef TERRAIN_OUTLINE_EN
    test_outline();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
